fetch_queue: RTL and testbench

//  Consumer end of the program-counter interface. Each cycle it captures {pc, instruction} from
//  the program counter and instruction memory into a small FIFO, then hands entries to decode

---
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-side instruction queue: captures {pc, instruction} each cycle and hands entries to decode
// over valid/ready, back-pressures the PC through stall, and drops wrong-path fetches on flush.
module fetch_queue #(
  parameter int ADDR_W       = 32,
  parameter int INSTR_W      = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_SHADOW = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               fetch_en,
  input  logic               flush,
  output logic               stall,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr
);

  localparam int               PTR_W       = $clog2(DEPTH);
  localparam int               CNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(DEPTH);
  localparam logic [2:0]       SHADOW_INIT = 3'(FLUSH_SHADOW);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t           storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [2:0]       shadow;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // stall depends only on registered count, so a pop never frees a slot in the same cycle.
  assign stall    = full;
  assign id_valid = !empty;
  assign id_pc    = storage[rd_ptr].pc;
  assign id_instr = storage[rd_ptr].instr;

  assign push = fetch_en && !full && (shadow == 3'd0) && !flush;
  assign pop  = id_valid && id_ready && !flush;

  always_comb begin
    // NOTE: default assigned first so every path drives count_next and no latch is inferred.
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: storage is cleared on reset so id_pc/id_instr read zero while the queue is empty.
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      shadow <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      shadow <= SHADOW_INIT;
    end else begin
      if (push) begin
        storage[wr_ptr] <= '{pc: pc, instr: imem_data};
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      if (shadow != 3'd0) begin
        shadow <= shadow - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stream, fill/stall, flush shadow, pointer wrap,
// asynchronous reset and simultaneous push/pop, with hand-derived expectations.
module tb_fetch_queue;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] imem_data;
  logic        fetch_en;
  logic        flush;
  logic        stall;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int vectors;
  int miscompares;

  fetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4), .FLUSH_SHADOW(1)
  ) dut (
    .clock(clock), .reset(reset), .pc(pc), .imem_data(imem_data),
    .fetch_en(fetch_en), .flush(flush), .stall(stall), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [31:0] a);
    fetch_en  = 1'b1;
    pc        = a;
    imem_data = instr_of(a);
  endtask

  task automatic check_head(input string tag, input logic [31:0] a);
    check({tag, "_valid"}, 64'(id_valid), 64'(1'b1));
    check({tag, "_pc"}, 64'(id_pc), 64'(a));
    check({tag, "_instr"}, 64'(id_instr), 64'(instr_of(a)));
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 64'(id_valid), 64'(1'b0));
    check({tag, "_stall"}, 64'(stall), 64'(1'b0));
  endtask

  logic [31:0] exp_q[$];
  logic [4:0]  ready_pat;
  logic        m_push;
  logic        m_pop;
  int          k;
  int          cyc;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    pc          = '0;
    imem_data   = '0;
    fetch_en    = 1'b0;
    flush       = 1'b0;
    id_ready    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 64'(id_valid), 64'(1'b0));
    check("rst_stall", 64'(stall), 64'(1'b0));
    check("rst_pc", 64'(id_pc), 64'h0);
    check("rst_instr", 64'(id_instr), 64'h0);
    #2 reset = 1'b1;

    // 1. Stream: each fetch visible one cycle later, queue never backs up
    id_ready = 1'b1;
    present(BASE);
    tick();
    check_head("stream0", BASE);
    check("stream0_stall", 64'(stall), 64'(1'b0));
    present(BASE + 32'h4);
    tick();
    check_head("stream1", BASE + 32'h4);
    check("stream1_stall", 64'(stall), 64'(1'b0));
    present(BASE + 32'h8);
    tick();
    check_head("stream2", BASE + 32'h8);
    check("stream2_stall", 64'(stall), 64'(1'b0));
    fetch_en = 1'b0;
    tick();
    check_empty("stream_end");

    // 2. Fill: four pushes raise stall; held fetch enters only after a pop frees a slot
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(BASE + 32'(4 * i));
      tick();
      check("fill_stall", 64'(stall), 64'(i == 3));
    end
    check_head("fill_head", BASE);
    present(BASE + 32'h10);
    tick();
    check("fill_held_stall", 64'(stall), 64'(1'b1));
    check_head("fill_held_head", BASE);
    id_ready = 1'b1;
    tick();
    check("fill_pop_stall", 64'(stall), 64'(1'b0));
    check_head("fill_pop_head", BASE + 32'h4);
    id_ready = 1'b0;
    tick();
    check("fill_refill_stall", 64'(stall), 64'(1'b1));
    fetch_en = 1'b0;
    id_ready = 1'b1;
    tick();
    check_head("drain0", BASE + 32'h8);
    tick();
    check_head("drain1", BASE + 32'hC);
    tick();
    check_head("drain2", BASE + 32'h10);
    tick();
    check_empty("drain_end");

    // 3. Flush: queued entries discarded, shadow drops the next fetch, target gets through
    id_ready = 1'b0;
    present(BASE + 32'h8);
    tick();
    present(BASE + 32'hC);
    tick();
    check_head("flush_pre", BASE + 32'h8);
    flush    = 1'b1;
    id_ready = 1'b1;
    present(BASE + 32'h10);
    tick();
    flush = 1'b0;
    check_empty("flush_now");
    present(BASE + 32'h10);
    tick();
    check_empty("flush_shadow_drop");
    present(BASE + 32'h100);
    id_ready = 1'b0;
    tick();
    check_head("flush_target", BASE + 32'h100);
    fetch_en = 1'b0;
    id_ready = 1'b1;
    tick();
    check_empty("flush_target_popped");

    // Back-to-back flush re-arms the shadow each cycle
    flush = 1'b1;
    present(BASE + 32'h200);
    tick();
    tick();
    flush = 1'b0;
    present(BASE + 32'h204);
    tick();
    check_empty("flush2_drop");
    present(BASE + 32'h208);
    id_ready = 1'b0;
    tick();
    check_head("flush2_target", BASE + 32'h208);
    fetch_en = 1'b0;
    id_ready = 1'b1;
    tick();
    check_empty("flush2_end");

    // 4. Wrap: ten fetches against ready pattern 1,0,1,1,0 with a reference FIFO
    ready_pat = 5'b01101;
    k   = 0;
    cyc = 0;
    while ((k < 10 || exp_q.size() != 0) && cyc < 80) begin
      id_ready  = ready_pat[cyc % 5];
      fetch_en  = (k < 10);
      pc        = BASE + 32'(4 * k);
      imem_data = instr_of(pc);
      m_push    = fetch_en && (exp_q.size() < 4);
      m_pop     = id_ready && (exp_q.size() != 0);
      tick();
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        exp_q.push_back(pc);
        k++;
      end
      check("wrap_valid", 64'(id_valid), 64'(exp_q.size() != 0));
      check("wrap_stall", 64'(stall), 64'(exp_q.size() == 4));
      if (exp_q.size() != 0) begin
        check("wrap_pc", 64'(id_pc), 64'(exp_q[0]));
        check("wrap_instr", 64'(id_instr), 64'(instr_of(exp_q[0])));
      end
      cyc++;
    end
    check("wrap_pushed", 64'(k), 64'd10);
    check("wrap_drained", 64'(exp_q.size()), 64'd0);
    fetch_en = 1'b0;
    id_ready = 1'b0;

    // 6. Simultaneous push+pop at count 2 keeps occupancy and order
    present(BASE + 32'h300);
    tick();
    present(BASE + 32'h304);
    tick();
    id_ready = 1'b1;
    for (int i = 2; i < 7; i++) begin
      present(BASE + 32'h300 + 32'(4 * i));
      tick();
      check_head("pushpop", BASE + 32'h300 + 32'(4 * (i - 1)));
      check("pushpop_stall", 64'(stall), 64'(1'b0));
    end
    fetch_en = 1'b0;
    tick();
    check_head("pushpop_drain", BASE + 32'h318);
    tick();
    check_empty("pushpop_end");

    // 5. Async reset between edges clears outputs immediately
    id_ready = 1'b0;
    present(BASE + 32'h400);
    tick();
    present(BASE + 32'h404);
    tick();
    present(BASE + 32'h408);
    tick();
    fetch_en = 1'b0;
    check_head("areset_pre", BASE + 32'h400);
    check("areset_pre_stall", 64'(stall), 64'(1'b0));
    #2 reset = 1'b0;
    #1;
    check("areset_valid", 64'(id_valid), 64'(1'b0));
    check("areset_pc", 64'(id_pc), 64'h0);
    check("areset_instr", 64'(id_instr), 64'h0);
    check("areset_stall", 64'(stall), 64'(1'b0));
    tick();
    #2 reset = 1'b1;
    present(BASE);
    tick();
    check_head("areset_first", BASE);
    fetch_en = 1'b0;
    id_ready = 1'b1;
    tick();
    check_empty("areset_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
